// File: rtl/everloop_arb_pkg.sv
// Shared types and defaults for the everloop Wishbone arbiter.
package everloop_arb_pkg;

  localparam int unsigned GAP_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_GAP
  } arb_state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; a held lock keeps the grant with the last owner.
module rr_arb2
  import everloop_arb_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       lock,
  output gnt_e       gnt,
  output logic       gnt_vld
);

  gnt_e last_q;

  // Last-granted port; reset makes port A the preferred one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_q <= GNT_B;
    end else if (advance) begin
      last_q <= gnt;
    end
  end

  always_comb begin
    gnt     = GNT_A;
    gnt_vld = 1'b0;
    if (lock) begin
      gnt     = last_q;
      gnt_vld = (last_q == GNT_A) ? req[0] : req[1];
    end else if (req[0] && req[1]) begin
      gnt     = (last_q == GNT_A) ? GNT_B : GNT_A;
      gnt_vld = 1'b1;
    end else if (req[0]) begin
      gnt     = GNT_A;
      gnt_vld = 1'b1;
    end else if (req[1]) begin
      gnt     = GNT_B;
      gnt_vld = 1'b1;
    end
  end

endmodule

// File: rtl/everloop_wb_arb.sv
// Two-master Wishbone arbiter/sequencer for the everloop LED-ring slave.
// Define EVERLOOP_ARB_LOCK_EN to add per-port ownership lock inputs.
module everloop_wb_arb
  import everloop_arb_pkg::*;
#(
  parameter int unsigned ADR_W      = 14,
  parameter int unsigned DAT_W      = 16,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             a_cyc_i,
  input  logic             a_stb_i,
  input  logic             a_we_i,
  input  logic [ADR_W-1:0] a_adr_i,
  input  logic [1:0]       a_sel_i,
  input  logic [DAT_W-1:0] a_dat_i,
  output logic [DAT_W-1:0] a_dat_o,
  output logic             a_ack_o,
  input  logic             b_cyc_i,
  input  logic             b_stb_i,
  input  logic             b_we_i,
  input  logic [ADR_W-1:0] b_adr_i,
  input  logic [1:0]       b_sel_i,
  input  logic [DAT_W-1:0] b_dat_i,
  output logic [DAT_W-1:0] b_dat_o,
  output logic             b_ack_o,
`ifdef EVERLOOP_ARB_LOCK_EN
  input  logic             a_lock_i,
  input  logic             b_lock_i,
`endif
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [1:0]       s_sel_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i
);

  localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e       state;
  gnt_e             gnt;
  gnt_e             gnt_q;
  logic             gnt_vld;
  logic             owned;
  logic [CNT_W-1:0] gap_cnt;
  logic             a_lock;
  logic             b_lock;
  logic             own_cyc;

`ifdef EVERLOOP_ARB_LOCK_EN
  assign a_lock = a_lock_i;
  assign b_lock = b_lock_i;
`else
  assign a_lock = 1'b0;
  assign b_lock = 1'b0;
`endif

  assign own_cyc = (gnt_q == GNT_A) ? a_cyc_i : b_cyc_i;

  rr_arb2 u_rr (
    .clk     (clk),
    .nrst    (nrst),
    .req     ({b_cyc_i & b_stb_i, a_cyc_i & a_stb_i}),
    .advance (state == ST_IDLE && gnt_vld),
    .lock    (owned),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  // Sequencer: one-cycle slave strobe, generated ack, post-write idle gap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      gnt_q   <= GNT_A;
      owned   <= 1'b0;
      gap_cnt <= '0;
      s_cyc_o <= 1'b0;
      s_stb_o <= 1'b0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_sel_o <= '0;
      s_dat_o <= '0;
      a_ack_o <= 1'b0;
      b_ack_o <= 1'b0;
      a_dat_o <= '0;
      b_dat_o <= '0;
    end else begin
      a_ack_o <= 1'b0;
      b_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (owned && !own_cyc) owned <= 1'b0;
          if (gnt_vld) begin
            gnt_q <= gnt;
            if (gnt == GNT_A) begin
              s_we_o  <= a_we_i;
              s_adr_o <= a_adr_i;
              s_sel_o <= a_sel_i;
              s_dat_o <= a_dat_i;
            end else begin
              s_we_o  <= b_we_i;
              s_adr_o <= b_adr_i;
              s_sel_o <= b_sel_i;
              s_dat_o <= b_dat_i;
            end
            s_cyc_o <= 1'b1;
            s_stb_o <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          s_cyc_o <= 1'b0;
          s_stb_o <= 1'b0;
          state   <= ST_ACK;
          // An abandoned cycle gets no ack, but the slave access already happened.
          if (gnt_q == GNT_A && a_cyc_i) begin
            a_ack_o <= 1'b1;
            if (!s_we_o) a_dat_o <= s_dat_i;
          end
          if (gnt_q == GNT_B && b_cyc_i) begin
            b_ack_o <= 1'b1;
            if (!s_we_o) b_dat_o <= s_dat_i;
          end
        end
        ST_ACK: begin
          owned <= (gnt_q == GNT_A) ? a_lock : b_lock;
          if (s_we_o) begin
            gap_cnt <= CNT_W'(GAP_CYCLES - 1);
            state   <= ST_GAP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
